// File: rtl/shift_issue_buffer_pkg.sv
// Shared definitions for the shifter issue buffer: request field widths,
// op encodings and the packed request record stored in the FIFO.
package shift_issue_buffer_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam int OP_W   = 2;
  localparam int REQ_W  = OP_W + AMT_W + DATA_W;

  // 2'b11 is decoded by the shifter exactly like SLL.
  typedef enum logic [OP_W-1:0] {
    SH_OP_SRA     = 2'b00,
    SH_OP_SRL     = 2'b01,
    SH_OP_SLL     = 2'b10,
    SH_OP_SLL_ALT = 2'b11
  } sh_op_e;

  typedef struct packed {
    logic [OP_W-1:0]   aluc;
    logic [AMT_W-1:0]  b;
    logic [DATA_W-1:0] a;
  } sh_req_t;

  function automatic sh_req_t make_req(input logic [DATA_W-1:0] a,
                                       input logic [AMT_W-1:0]  b,
                                       input logic [OP_W-1:0]   aluc);
    sh_req_t r;
    r.aluc = aluc;
    r.b    = b;
    r.a    = a;
    return r;
  endfunction

endpackage

// File: rtl/shift_issue_buffer_fifo.sv
// Circular request FIFO holding {aluc,b,a}; exposes the head combinationally
// and a registered occupancy count from which full/empty are derived.
module shift_req_fifo
  import shift_issue_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  sh_req_t         wdata,
  output sh_req_t         rdata,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  sh_req_t           mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/shift_issue_buffer.sv
// Issue stage for the external barrel shifter: queues requests, presents the
// FIFO head on sh_*, and registers the shifter result behind out_valid/out_ready.
module shift_issue_buffer
  import shift_issue_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [AMT_W-1:0]  in_b,
  input  logic [OP_W-1:0]   in_aluc,
  output logic [DATA_W-1:0] sh_a,
  output logic [AMT_W-1:0]  sh_b,
  output logic [OP_W-1:0]   sh_aluc,
  input  logic [DATA_W-1:0] sh_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic [ADDR_W:0]   count
);

  sh_req_t wreq;
  sh_req_t head;
  logic    fifo_full;
  logic    fifo_empty;
  logic    push;
  logic    pop;

  // in_ready looks only at registered occupancy so a full FIFO never
  // accepts in the same cycle it pops.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign pop      = ~fifo_empty & (~out_valid | out_ready);
  assign wreq     = make_req(in_a, in_b, in_aluc);

  shift_req_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wreq),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sh_a    = fifo_empty ? '0 : head.a;
  assign sh_b    = fifo_empty ? '0 : head.b;
  assign sh_aluc = fifo_empty ? '0 : head.aluc;

  // out_c keeps its last value after a drain; only an issue reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_c     <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_c     <= sh_c;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_issue_buffer.sv
// Directed and random bench for shift_issue_buffer with a barrel shifter model
// on sh_* and a queue of expected results in acceptance order.
module tb_shift_issue_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_b;
  logic [1:0]  in_aluc;
  logic [31:0] sh_a;
  logic [4:0]  sh_b;
  logic [1:0]  sh_aluc;
  logic [31:0] sh_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  int produced = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  shift_issue_buffer #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_aluc   (in_aluc),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .sh_aluc   (sh_aluc),
    .sh_c      (sh_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .count     (count)
  );

  always_comb begin
    case (sh_aluc)
      2'b00:   sh_c = $unsigned($signed(sh_a) >>> sh_b);
      2'b01:   sh_c = sh_a >> sh_b;
      default: sh_c = sh_a << sh_b;
    endcase
  end

  // Bit-by-bit reference, deliberately independent of the operator-based model.
  function automatic logic [31:0] shift_ref(input logic [31:0] a, input logic [4:0] b,
                                            input logic [1:0] aluc);
    logic [31:0] r;
    int idx;
    for (int k = 0; k < 32; k++) begin
      if (aluc[1]) begin
        idx = k - int'(b);
        if (idx >= 0) r[k] = a[idx];
        else          r[k] = 1'b0;
      end else begin
        idx = k + int'(b);
        if (idx <= 31)    r[k] = a[idx];
        else if (aluc[0]) r[k] = 1'b0;
        else              r[k] = a[31];
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [4:0] b,
                               input logic [1:0] aluc, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_aluc   = aluc;
    out_ready = ordy;
  endtask

  // One clock: handshakes are evaluated at the negedge, then the bench resumes 1 unit after posedge.
  task automatic cycle();
    logic in_fire;
    logic out_fire;
    @(negedge clk);
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    if (!rst) begin
      if (out_fire) begin
        produced++;
        checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) checkOutput("sb_out_c", out_c, sb.pop_front());
      end
      if (in_fire) begin
        accepted++;
        sb.push_back(shift_ref(in_a, in_b, in_aluc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
    for (int c = 0; c < 50 && (sb.size() != 0 || out_valid); c++) cycle();
    checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    checkOutput({tag, "_ov_low"}, 32'(out_valid), 32'd0);
  endtask

  task automatic send_one(input string tag, input logic [31:0] a, input logic [4:0] b,
                          input logic [1:0] aluc, input logic [31:0] exp_c);
    applyStimulus(1'b1, a, b, aluc, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
    checkOutput({tag, "_head_a"}, sh_a, a);
    checkOutput({tag, "_ov_n1"}, 32'(out_valid), 32'd0);
    cycle();
    checkOutput({tag, "_ov_n2"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_out_c"}, out_c, exp_c);
    cycle();
  endtask

  initial begin
    int a0;
    int p0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_c", out_c, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_sh_a", sh_a, 32'd0);

    $display("[TB] directed shifts");
    send_one("t1_sra", 32'h8000_0000, 5'd4, 2'b00, 32'hF800_0000);
    send_one("t2_srl", 32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000);
    send_one("t2_sll", 32'h0000_0001, 5'd31, 2'b10, 32'h8000_0000);
    send_one("t2_sll11", 32'h0000_0001, 5'd31, 2'b11, 32'h8000_0000);
    send_one("t2_b0", 32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678);
    send_one("t2_sra_pos", 32'h7000_0000, 5'd31, 2'b00, 32'h0000_0000);

    $display("[TB] full with stalled consumer");
    a0 = accepted;
    p0 = produced;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'hA5A5_0000 + 32'(i), 5'(i + 1), 2'(i), 1'b0);
      cycle();
    end
    checkOutput("t3_accepted", 32'(accepted - a0), 32'd5);
    checkOutput("t3_in_ready", 32'(in_ready), 32'd0);
    checkOutput("t3_count", 32'(count), 32'd4);
    checkOutput("t3_out_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
    cycle();
    checkOutput("t3_in_ready_after_pop", 32'(in_ready), 32'd1);
    drain("t3");
    checkOutput("t3_produced", 32'(produced - p0), 32'd5);

    $display("[TB] back-to-back stream");
    a0 = accepted;
    p0 = produced;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'hC000_0001 ^ (32'(i) << 8), 5'(3 * i), 2'(i), 1'b1);
      cycle();
      checkOutput("t4_count_le1", 32'(count <= 3'd1), 32'd1);
      if (i >= 1) checkOutput("t4_out_valid", 32'(out_valid), 32'd1);
    end
    drain("t4");
    checkOutput("t4_accepted", 32'(accepted - a0), 32'd16);
    checkOutput("t4_produced", 32'(produced - p0), 32'd16);

    $display("[TB] random traffic");
    a0 = accepted;
    p0 = produced;
    for (int c = 0; c < 20000 && (accepted - a0) < 1000; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 7));
      cycle();
    end
    checkOutput("t5_accepted", 32'(accepted - a0), 32'd1000);
    drain("t5");
    checkOutput("t5_produced", 32'(produced - p0), 32'd1000);

    $display("[TB] reset with work in flight");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h0F0F_0000 + 32'(i), 5'd1, 2'b10, 1'b0);
      cycle();
    end
    checkOutput("t6_pre_count", 32'(count), 32'd3);
    checkOutput("t6_pre_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 5'd1, 2'b01, 1'b1);
    cycle();
    rst = 1'b0;
    sb.delete();
    applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
    checkOutput("t6_count", 32'(count), 32'd0);
    checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_out_c", out_c, 32'd0);
    checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t6_sh_a", sh_a, 32'd0);
    checkOutput("t6_sh_b", 32'(sh_b), 32'd0);
    checkOutput("t6_sh_aluc", 32'(sh_aluc), 32'd0);
    p0 = produced;
    for (int i = 0; i < 5; i++) cycle();
    checkOutput("t6_no_stale_out", 32'(produced - p0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
